linescanner_frame_controller: RTL and testbench
===============================================

// Module: linescanner_frame_controller
// PURPOSE
//  Sequences the linescanner capture unit over whole frames: drives its enable, frames its lval/data stream
//  into counted lines, and emits a registered pixel stream with SOF/SOL/EOL/EOF markers.
//  Inserts a programmable inter-line gap and supports single-shot or continuous frames.
//  Sits between the host control registers and the capture unit.
// PARAMETERS
//  DATA_WIDTH      8      pixel width
//  PIX_CNT_WIDTH   12     width of pixels-per-line counter/config
//  LINE_CNT_WIDTH  16     width of lines-per-frame counter/config
//  GAP_CNT_WIDTH   16     width of inter-line gap counter/config (clocks)
//  TIMEOUT_CLOCKS  65535  WAIT_LVAL watchdog limit; used only with LINESCANNER_TIMEOUT_EN
// PORTS
//  main_clock           in   1    single system clock; all logic on rising edge
//  reset                in   1    asynchronous, active-high reset
//  start                in   1    1-clk pulse; begins a frame when IDLE
//  stop                 in   1    level; finish current line, then IDLE
//  continuous           in   1    sampled at frame end; 1 = start next frame automatically
//  cfg_pixels_per_line  in   PIX_CNT_WIDTH   expected pixels per line (latched at frame start)
//  cfg_lines_per_frame  in   LINE_CNT_WIDTH  lines per frame (latched at frame start)
//  cfg_line_gap         in   GAP_CNT_WIDTH   idle clocks between lines (latched at frame start)
//  lval                 in   1    line-valid from sensor; each main_clock cycle with lval=1 is one pixel
//  pixel_data           in   DATA_WIDTH  pixel from capture unit
//  capture_enable       out  1    enable to capture unit
//  out_data             out  DATA_WIDTH  registered pixel
//  out_valid / out_sof / out_sol / out_eol / out_eof  out 1 each  stream qualifiers/markers
//  busy                 out  1    1 when not IDLE
//  frame_done           out  1    1-clk pulse at end of last line
//  line_count           out  LINE_CNT_WIDTH  index of the line currently being captured
//  err_short / err_long / err_timeout  out 1 each  sticky; cleared by the next accepted start
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; counters 0; latched cfg 0.
//  States: IDLE, ARM, WAIT_LVAL, CAPTURE, LINE_GAP.
//  IDLE: start=1 and both cfg_pixels_per_line!=0 and cfg_lines_per_frame!=0 -> latch cfg, clear errors,
//    line_count=0 -> ARM. Any zero cfg: start ignored, state stays IDLE.
//  ARM: capture_enable<=1 -> WAIT_LVAL (enable is high from 1 clk after start).
//  WAIT_LVAL: capture_enable held 1; lval=1 -> CAPTURE with capture_enable<=0; that cycle is pixel 0.
//  CAPTURE: pixel index increments each lval=1 cycle.
//  CAPTURE, lval falls -> short check (index<cfg sets err_short) -> LINE_GAP, or IDLE if stop=1 at that cycle.
//  Latency: pixel sampled on cycle N appears on out_data/out_valid on cycle N+1.
//  Pixels with index>=cfg_pixels_per_line: dropped (out_valid=0) and err_long set.
//  Markers (qualified by out_valid): out_sol on index 0; out_eol on index cfg-1; out_sof = sol of line 0;
//  out_eof = eol of line cfg_lines-1. A short line produces no eol/eof.
//  LINE_GAP: counts cfg_line_gap clocks (0 -> 1 clk pass-through). At gap end:
//    line_count<cfg_lines-1: line_count++ -> ARM.
//    last line done: frame_done pulse.
//      continuous=1 and stop=0: re-latch cfg, line_count=0 -> ARM.
//      otherwise: IDLE.
//  stop asserted outside CAPTURE: transitions to IDLE on the next clock, capture_enable<=0.
//  start while busy: ignored.
//  Counters saturate at their width; no wrap-around inside a frame.
// CONFIGURATION
//  LINESCANNER_TIMEOUT_EN defined:
//    watchdog counts cycles in WAIT_LVAL.
//    Reaching TIMEOUT_CLOCKS sets err_timeout, drops capture_enable -> IDLE; no frame_done.
//  LINESCANNER_TIMEOUT_EN undefined: WAIT_LVAL waits indefinitely; err_timeout tied 0.
// STRUCTURE
//  Shared include linescanner_defs.vh: state encodings, marker/error bit positions, default widths.
//  One sub-module: linescanner_cycle_timer (load/count/expire).
//    Instanced for LINE_GAP, and for the watchdog when enabled.
// TESTING
//  1. cfg 4 px/3 lines/gap 2, start, 3 lval bursts of 4.
//     -> 12 out_valid; sof on first pixel; sol x3; eol x3; eof on 12th pixel; one frame_done; busy falls.
//  2. Latency: pixel_data=0xA5 with lval on cycle N -> out_data=0xA5, out_valid=1 on N+1.
//  3. lval burst of 3 with cfg 4 -> err_short=1, no eol.
//     Burst of 6 -> pixels 4,5 dropped, err_long=1.
//  4. continuous=1, 2 lines/frame -> second frame starts after gap with line_count=0.
//     stop mid-line -> line finishes, then IDLE.
//  5. reset asserted mid-CAPTURE -> outputs 0 immediately (async); start with cfg_lines=0 -> stays IDLE.
//  6. TIMEOUT_EN, TIMEOUT_CLOCKS=16, no lval
//     -> err_timeout after 16 clks in WAIT_LVAL, capture_enable=0, IDLE.

Source files
------------

// File: rtl/linescanner_frame_controller_pkg.sv
// Shared definitions for the linescanner frame controller: FSM state encoding,
// marker/error bit positions, default widths and a marker helper.
package linescanner_frame_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_LVAL = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_LINE_GAP  = 3'd4
    } state_t;

    // Bit positions inside the packed marker vector
    localparam int MARK_SOF  = 0;
    localparam int MARK_SOL  = 1;
    localparam int MARK_EOL  = 2;
    localparam int MARK_EOF  = 3;
    localparam int MARK_BITS = 4;

    // Bit positions inside the packed sticky-error vector
    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;
    localparam int ERR_BITS  = 2;

    // Default widths
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_PIX_CNT_WIDTH  = 12;
    localparam int DEF_LINE_CNT_WIDTH = 16;
    localparam int DEF_GAP_CNT_WIDTH  = 16;
    localparam int DEF_TIMEOUT_CLOCKS = 65535;

    // Builds the marker set for one accepted pixel: frame markers are line
    // markers restricted to the first/last line of the frame.
    function automatic logic [MARK_BITS-1:0] make_marks(input logic sol,
                                                        input logic eol,
                                                        input logic first_line,
                                                        input logic last_line);
        logic [MARK_BITS-1:0] m;
        m           = '0;
        m[MARK_SOL] = sol;
        m[MARK_EOL] = eol;
        m[MARK_SOF] = sol & first_line;
        m[MARK_EOF] = eol & last_line;
        return m;
    endfunction

endpackage

// File: rtl/linescanner_cycle_timer.sv
// Load/count/expire down-counter. Holds the remaining clocks of an interval;
// expired is high on the last clock of the interval (a load of 0 or 1 gives
// a single-clock interval).
module linescanner_cycle_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_en,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] remaining_reg;

    assign expired = (remaining_reg <= ONE);

    // Reload while idle, count down while enabled, stop at the last clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_reg <= '0;
        end else if (load) begin
            remaining_reg <= load_value;
        end else if (count_en && !expired) begin
            remaining_reg <= remaining_reg - ONE;
        end
    end

endmodule

// File: rtl/linescanner_frame_controller.sv
// Linescanner frame controller: sequences the capture unit over whole frames,
// counts lines/pixels and emits a registered pixel stream with SOF/SOL/EOL/EOF.
// Optional WAIT_LVAL watchdog enabled by defining LINESCANNER_TIMEOUT_EN.
module linescanner_frame_controller
    import linescanner_frame_controller_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PIX_CNT_WIDTH  = DEF_PIX_CNT_WIDTH,
    parameter int LINE_CNT_WIDTH = DEF_LINE_CNT_WIDTH,
    parameter int GAP_CNT_WIDTH  = DEF_GAP_CNT_WIDTH,
    parameter int TIMEOUT_CLOCKS = DEF_TIMEOUT_CLOCKS
) (
    input  logic                      main_clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      continuous,
    input  logic [PIX_CNT_WIDTH-1:0]  cfg_pixels_per_line,
    input  logic [LINE_CNT_WIDTH-1:0] cfg_lines_per_frame,
    input  logic [GAP_CNT_WIDTH-1:0]  cfg_line_gap,
    input  logic                      lval,
    input  logic [DATA_WIDTH-1:0]     pixel_data,
    output logic                      capture_enable,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    output logic                      out_sof,
    output logic                      out_sol,
    output logic                      out_eol,
    output logic                      out_eof,
    output logic                      busy,
    output logic                      frame_done,
    output logic [LINE_CNT_WIDTH-1:0] line_count,
    output logic                      err_short,
    output logic                      err_long,
    output logic                      err_timeout
);

    localparam logic [PIX_CNT_WIDTH-1:0]  PIX_ONE  = PIX_CNT_WIDTH'(1);
    localparam logic [LINE_CNT_WIDTH-1:0] LINE_ONE = LINE_CNT_WIDTH'(1);

    state_t                    state;
    logic [PIX_CNT_WIDTH-1:0]  cfg_pix_reg;
    logic [LINE_CNT_WIDTH-1:0] cfg_lines_reg;
    logic [GAP_CNT_WIDTH-1:0]  cfg_gap_reg;
    logic [PIX_CNT_WIDTH-1:0]  pix_idx_reg;
    logic [MARK_BITS-1:0]      marks_reg;
    logic [ERR_BITS-1:0]       err_reg;

    logic [PIX_CNT_WIDTH-1:0]  cur_idx;
    logic                      pix_in_range;
    logic [MARK_BITS-1:0]      pix_marks;
    logic                      line_first;
    logic                      line_last;
    logic                      cfg_ok;
    logic                      gap_expired;

    assign out_sof   = marks_reg[MARK_SOF];
    assign out_sol   = marks_reg[MARK_SOL];
    assign out_eol   = marks_reg[MARK_EOL];
    assign out_eof   = marks_reg[MARK_EOF];
    assign err_short = err_reg[ERR_SHORT];
    assign err_long  = err_reg[ERR_LONG];

    // Index and markers of the pixel presented this cycle (WAIT_LVAL hit is pixel 0)
    always_comb begin
        cur_idx      = (state == ST_WAIT_LVAL) ? '0 : pix_idx_reg;
        pix_in_range = (cur_idx < cfg_pix_reg);
        line_first   = (line_count == '0);
        line_last    = (line_count == cfg_lines_reg - LINE_ONE);
        pix_marks    = make_marks(cur_idx == '0, cur_idx == cfg_pix_reg - PIX_ONE,
                                  line_first, line_last);
        cfg_ok       = (cfg_pixels_per_line != '0) && (cfg_lines_per_frame != '0);
    end

    // Inter-line gap timer: reloaded outside LINE_GAP, runs inside it
    linescanner_cycle_timer #(
        .WIDTH(GAP_CNT_WIDTH)
    ) u_gap_timer (
        .clk        (main_clock),
        .rst        (reset),
        .load       (state != ST_LINE_GAP),
        .load_value (cfg_gap_reg),
        .count_en   (state == ST_LINE_GAP),
        .expired    (gap_expired)
    );

`ifdef LINESCANNER_TIMEOUT_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT_CLOCKS + 1);
    localparam logic [WD_WIDTH-1:0] WD_LOAD = WD_WIDTH'(TIMEOUT_CLOCKS);

    logic err_timeout_reg;
    logic wd_expired;

    assign err_timeout = err_timeout_reg;

    // Watchdog on WAIT_LVAL: reloaded elsewhere, expires after TIMEOUT_CLOCKS clocks
    linescanner_cycle_timer #(
        .WIDTH(WD_WIDTH)
    ) u_watchdog (
        .clk        (main_clock),
        .rst        (reset),
        .load       (state != ST_WAIT_LVAL),
        .load_value (WD_LOAD),
        .count_en   (state == ST_WAIT_LVAL),
        .expired    (wd_expired)
    );
`else
    // No watchdog: timeout can never occur (the term keeps the limit referenced)
    assign err_timeout = 1'b0 & (TIMEOUT_CLOCKS == 0);
`endif

    // Frame sequencer with registered stream, markers, status and errors
    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            capture_enable <= 1'b0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            marks_reg      <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            line_count     <= '0;
            err_reg        <= '0;
            cfg_pix_reg    <= '0;
            cfg_lines_reg  <= '0;
            cfg_gap_reg    <= '0;
            pix_idx_reg    <= '0;
`ifdef LINESCANNER_TIMEOUT_EN
            err_timeout_reg <= 1'b0;
`endif
        end else begin
            out_valid  <= 1'b0;
            marks_reg  <= '0;
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start && cfg_ok) begin
                        cfg_pix_reg   <= cfg_pixels_per_line;
                        cfg_lines_reg <= cfg_lines_per_frame;
                        cfg_gap_reg   <= cfg_line_gap;
                        err_reg       <= '0;
`ifdef LINESCANNER_TIMEOUT_EN
                        err_timeout_reg <= 1'b0;
`endif
                        line_count    <= '0;
                        busy          <= 1'b1;
                        state         <= ST_ARM;
                    end
                end

                ST_ARM: begin
                    if (stop) begin
                        capture_enable <= 1'b0;
                        busy           <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        capture_enable <= 1'b1;
                        state          <= ST_WAIT_LVAL;
                    end
                end

                ST_WAIT_LVAL: begin
                    if (stop) begin
                        capture_enable <= 1'b0;
                        busy           <= 1'b0;
                        state          <= ST_IDLE;
                    end else if (lval) begin
                        // Pixel 0 is always within a non-zero line length
                        capture_enable <= 1'b0;
                        out_valid      <= 1'b1;
                        out_data       <= pixel_data;
                        marks_reg      <= pix_marks;
                        pix_idx_reg    <= PIX_ONE;
                        state          <= ST_CAPTURE;
`ifdef LINESCANNER_TIMEOUT_EN
                    end else if (wd_expired) begin
                        err_timeout_reg <= 1'b1;
                        capture_enable  <= 1'b0;
                        busy            <= 1'b0;
                        state           <= ST_IDLE;
`endif
                    end
                end

                ST_CAPTURE: begin
                    if (lval) begin
                        if (pix_in_range) begin
                            out_valid <= 1'b1;
                            out_data  <= pixel_data;
                            marks_reg <= pix_marks;
                        end else begin
                            err_reg[ERR_LONG] <= 1'b1;
                        end
                        if (pix_idx_reg != '1) begin
                            pix_idx_reg <= pix_idx_reg + PIX_ONE;
                        end
                    end else begin
                        // End of line: a stop request takes effect only here
                        if (pix_idx_reg < cfg_pix_reg) begin
                            err_reg[ERR_SHORT] <= 1'b1;
                        end
                        if (stop) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_LINE_GAP;
                        end
                    end
                end

                ST_LINE_GAP: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (gap_expired) begin
                        if (!line_last) begin
                            line_count <= line_count + LINE_ONE;
                            state      <= ST_ARM;
                        end else begin
                            frame_done <= 1'b1;
                            if (continuous && cfg_ok) begin
                                cfg_pix_reg   <= cfg_pixels_per_line;
                                cfg_lines_reg <= cfg_lines_per_frame;
                                cfg_gap_reg   <= cfg_line_gap;
                                line_count    <= '0;
                                state         <= ST_ARM;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    capture_enable <= 1'b0;
                    busy           <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linescanner_frame_controller.sv
// Self-checking bench for linescanner_frame_controller: a table of per-clock
// vectors for a full 3-line frame, then hand-written multi-cycle sequences.
module tb_linescanner_frame_controller;

    logic        main_clock = 1'b0;
    logic        reset;
    logic        start, stop, continuous;
    logic [11:0] cfg_pixels_per_line;
    logic [15:0] cfg_lines_per_frame;
    logic [15:0] cfg_line_gap;
    logic        lval;
    logic [7:0]  pixel_data;
    logic        capture_enable;
    logic [7:0]  out_data;
    logic        out_valid, out_sof, out_sol, out_eol, out_eof;
    logic        busy, frame_done;
    logic [15:0] line_count;
    logic        err_short, err_long, err_timeout;

    int n_vec = 0;
    int n_bad = 0;

    linescanner_frame_controller #(
        .DATA_WIDTH     (8),
        .PIX_CNT_WIDTH  (12),
        .LINE_CNT_WIDTH (16),
        .GAP_CNT_WIDTH  (16),
        .TIMEOUT_CLOCKS (16)
    ) dut (
        .main_clock          (main_clock),
        .reset               (reset),
        .start               (start),
        .stop                (stop),
        .continuous          (continuous),
        .cfg_pixels_per_line (cfg_pixels_per_line),
        .cfg_lines_per_frame (cfg_lines_per_frame),
        .cfg_line_gap        (cfg_line_gap),
        .lval                (lval),
        .pixel_data          (pixel_data),
        .capture_enable      (capture_enable),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_sof             (out_sof),
        .out_sol             (out_sol),
        .out_eol             (out_eol),
        .out_eof             (out_eof),
        .busy                (busy),
        .frame_done          (frame_done),
        .line_count          (line_count),
        .err_short           (err_short),
        .err_long            (err_long),
        .err_timeout         (err_timeout)
    );

    always #5 main_clock = ~main_clock;

    typedef struct {
        logic        start;
        logic        stop;
        logic        lval;
        logic [7:0]  data;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [3:0]  exp_marks;   // {eof, eol, sol, sof}
        logic        exp_done;
        logic        exp_busy;
        logic        exp_cen;
        logic [15:0] exp_line;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sp, input logic lv, input logic [7:0] d,
                       input logic ev, input logic [7:0] ed, input logic [3:0] em,
                       input logic edn, input logic eb, input logic ec, input logic [15:0] el);
        vec_t v;
        v.start = st; v.stop = sp; v.lval = lv; v.data = d;
        v.exp_valid = ev; v.exp_data = ed; v.exp_marks = em;
        v.exp_done = edn; v.exp_busy = eb; v.exp_cen = ec; v.exp_line = el;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge main_clock);
        #1;
    endtask

    task automatic step(input logic st, input logic sp, input logic lv, input logic [7:0] d);
        start = st; stop = sp; lval = lv; pixel_data = d;
        tick();
    endtask

    logic [3:0]  got_marks;
    logic [7:0]  got_data;
    logic [7:0]  exp_data_q;
    logic        eol_seen;

    initial begin
        reset = 1'b1; start = 0; stop = 0; continuous = 0; lval = 0; pixel_data = 0;
        cfg_pixels_per_line = 12'd4; cfg_lines_per_frame = 16'd3; cfg_line_gap = 16'd2;
        repeat (2) tick();
        check("reset_outputs",
              {29'd0, capture_enable, out_data, out_valid, out_sof, out_sol, out_eol, out_eof,
               busy, frame_done, line_count, err_short, err_long, err_timeout}, 64'd0);
        reset = 1'b0;
        tick();

        // ---- Frame of 3 lines x 4 pixels, gap 2, as a per-clock table ----
        add(1, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 1, 0, 16'd0);   // IDLE -> ARM
        add(0, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 1, 1, 16'd0);   // ARM -> WAIT_LVAL
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < 4; p++) begin
                logic [7:0] d;
                d = 8'(8'h40 + l * 16 + p);
                add(0, 0, 1, d, 1, d,
                    {(p == 3 && l == 2), (p == 3), (p == 0), (p == 0 && l == 0)},
                    0, 1, 0, 16'(l));
            end
            add(0, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 1, 0, 16'(l)); // lval falls -> gap
            add(0, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 1, 0, 16'(l)); // gap clock 1
            if (l < 2) begin
                add(0, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 1, 0, 16'(l + 1)); // gap end -> ARM
                add(0, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 1, 1, 16'(l + 1)); // WAIT_LVAL
            end else begin
                add(0, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 1, 0, 0, 16'd2);      // frame_done
            end
        end
        add(0, 0, 0, 8'h00, 0, 8'h00, 4'b0000, 0, 0, 0, 16'd2);              // stays IDLE

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].lval, vecs[i].data);
            got_marks  = {out_eof, out_eol, out_sol, out_sof};
            got_data   = vecs[i].exp_valid ? out_data : 8'h00;
            exp_data_q = vecs[i].exp_valid ? vecs[i].exp_data : 8'h00;
            check($sformatf("vec[%0d]", i),
                  {33'd0, out_valid, got_data, got_marks, frame_done, busy, capture_enable, line_count},
                  {33'd0, vecs[i].exp_valid, exp_data_q, vecs[i].exp_marks, vecs[i].exp_done,
                   vecs[i].exp_busy, vecs[i].exp_cen, vecs[i].exp_line});
        end
        check("frame1_no_errors", {62'd0, err_short, err_long}, 64'd0);

        // ---- Short line, latency, then long line (4 px, 1 line, gap 0) ----
        cfg_pixels_per_line = 12'd4; cfg_lines_per_frame = 16'd1; cfg_line_gap = 16'd0;
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        check("latency_pre", {63'd0, out_valid}, 64'd0);
        step(0, 0, 1, 8'hA5);
        check("latency_a5", {55'd0, out_valid, out_data}, {55'd0, 1'b1, 8'hA5});
        eol_seen = out_eol;
        step(0, 0, 1, 8'h01); eol_seen = eol_seen | out_eol;
        step(0, 0, 1, 8'h02); eol_seen = eol_seen | out_eol | out_eof;
        step(0, 0, 0, 8'h00);
        check("short_err", {63'd0, err_short}, 64'd1);
        step(0, 0, 0, 8'h00);
        check("short_no_eol", {63'd0, eol_seen}, 64'd0);
        check("short_done", {62'd0, frame_done, busy}, {62'd0, 1'b1, 1'b0});

        step(1, 0, 0, 8'h00);
        check("start_clears_err", {62'd0, err_short, err_long}, 64'd0);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 8'(8'h30 + i));
            if (i < 4) check($sformatf("long_px%0d_valid", i), {63'd0, out_valid}, 64'd1);
            else       check($sformatf("long_px%0d_drop", i), {63'd0, out_valid}, 64'd0);
            if (i == 3) check("long_eol_eof", {62'd0, out_eol, out_eof}, {62'd0, 2'b11});
            if (i == 4) check("long_err", {63'd0, err_long}, 64'd1);
        end
        step(0, 0, 0, 8'h00);
        check("long_no_short", {63'd0, err_short}, 64'd0);
        step(0, 0, 0, 8'h00);
        check("long_done", {62'd0, frame_done, busy}, {62'd0, 1'b1, 1'b0});

        // ---- Continuous frames (2 px, 2 lines, gap 0), then stop mid-line ----
        cfg_pixels_per_line = 12'd2; cfg_lines_per_frame = 16'd2; cfg_line_gap = 16'd0;
        continuous = 1'b1;
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h11);
        check("cont_sof", {61'd0, out_valid, out_sof, out_sol}, {61'd0, 3'b111});
        step(0, 0, 1, 8'h12);
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        check("cont_line1", {48'd0, line_count}, 64'd1);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h21);
        check("cont_l1_sol_nosof", {62'd0, out_sol, out_sof}, {62'd0, 2'b10});
        step(0, 0, 1, 8'h22);
        check("cont_eof", {62'd0, out_eol, out_eof}, {62'd0, 2'b11});
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        check("cont_restart", {46'd0, frame_done, busy, line_count}, {46'd0, 1'b1, 1'b1, 16'd0});
        step(0, 0, 0, 8'h00);
        check("cont_rearm_cen", {63'd0, capture_enable}, 64'd1);
        step(0, 0, 1, 8'h31);
        check("cont_frame2_sof", {63'd0, out_sof}, 64'd1);
        step(0, 1, 1, 8'h32);
        check("stop_line_finishes", {55'd0, out_valid, out_data}, {55'd0, 1'b1, 8'h32});
        step(0, 1, 0, 8'h00);
        check("stop_idle", {61'd0, busy, capture_enable, frame_done}, 64'd0);
        continuous = 1'b0;
        step(0, 0, 0, 8'h00);
        check("stop_stays_idle", {63'd0, busy}, 64'd0);

        // ---- Async reset mid-capture; zero-line config is rejected ----
        cfg_pixels_per_line = 12'd4; cfg_lines_per_frame = 16'd3; cfg_line_gap = 16'd2;
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h77);
        check("pre_reset_valid", {62'd0, out_valid, busy}, {62'd0, 2'b11});
        #2 reset = 1'b1;
        #1;
        check("async_reset", {54'd0, out_valid, busy, out_data}, 64'd0);
        tick();
        reset = 1'b0;
        cfg_lines_per_frame = 16'd0;
        step(1, 0, 0, 8'h00);
        check("zero_cfg_ignored", {62'd0, busy, capture_enable}, 64'd0);
        step(0, 0, 0, 8'h00);
        check("zero_cfg_still_idle", {62'd0, busy, capture_enable}, 64'd0);
        cfg_lines_per_frame = 16'd3;

        // ---- WAIT_LVAL with no lval ----
        step(1, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
`ifdef LINESCANNER_TIMEOUT_EN
        repeat (15) step(0, 0, 0, 8'h00);
        check("wd_before_limit", {61'd0, busy, capture_enable, err_timeout}, {61'd0, 3'b110});
        step(0, 0, 0, 8'h00);
        check("wd_timeout", {60'd0, busy, capture_enable, err_timeout, frame_done},
              {60'd0, 4'b0010});
        step(1, 0, 0, 8'h00);
        check("wd_err_cleared", {63'd0, err_timeout}, 64'd0);
        step(0, 1, 0, 8'h00);
`else
        repeat (20) step(0, 0, 0, 8'h00);
        check("wait_no_timeout", {61'd0, busy, capture_enable, err_timeout}, {61'd0, 3'b110});
        step(0, 1, 0, 8'h00);
        check("wait_stop_idle", {62'd0, busy, capture_enable}, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
